// File: rtl/memory_stage.sv
// MEM stage: runs the dcache request handshake, picks the writeback value,
// latches MEM/WB and stalls the front of the pipe while an access is pending.
module memory_stage #(
   parameter int WORD_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              ex_dREN,
   input  logic              ex_dWEN,
   input  logic              ex_regWr,
   input  logic [1:0]        ex_regSel,
   input  logic [REG_W-1:0]  ex_regDst,
   input  logic              ex_halt,
   input  logic [WORD_W-1:0] ex_ALUOut,
   input  logic [WORD_W-1:0] ex_store,
   input  logic [WORD_W-1:0] ex_nPC,
   input  logic [WORD_W-1:0] ex_instr,
   input  logic              wb_en,
   input  logic              flush,
   input  logic              dhit,
   input  logic [WORD_W-1:0] dmemload,
   output logic              dmemREN,
   output logic              dmemWEN,
   output logic [WORD_W-1:0] dmemaddr,
   output logic [WORD_W-1:0] dmemstore,
   output logic              mem_stall,
   output logic              fwd_valid,
   output logic [REG_W-1:0]  fwd_reg,
   output logic [WORD_W-1:0] fwd_dat,
   output logic              wb_regWr,
   output logic [REG_W-1:0]  wb_regDst,
   output logic [WORD_W-1:0] wb_wdat,
   output logic              wb_halt,
   output logic [WORD_W-1:0] wb_instr
);

   // state | meaning
   // IDLE  | no access in flight; a new mem op issues its request this cycle
   // BUSY  | request outstanding, waiting for dhit
   // DONE  | access finished, result buffered until the MEM/WB latch takes it
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic              halted;
   logic              mem_op;
   logic              active;
   logic [WORD_W-1:0] load_buf;
   logic [WORD_W-1:0] wdat;

   assign mem_op = ex_dREN | ex_dWEN;

   // Gating with nRST withdraws the request immediately on a mid-access reset.
   assign active = nRST & ~halted & (((state == IDLE) & mem_op) | (state == BUSY));

   // Both bits set is illegal and is issued as a load.
   assign dmemREN   = active & ex_dREN;
   assign dmemWEN   = active & ex_dWEN & ~ex_dREN;
   assign mem_stall = active & ~dhit;
   assign dmemaddr  = ex_ALUOut;
   assign dmemstore = ex_store;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (active) state_nxt = dhit ? (wb_en ? IDLE : DONE) : BUSY;
         BUSY: if (dhit)   state_nxt = wb_en ? IDLE : DONE;
         DONE: if (wb_en)  state_nxt = IDLE;
         default:          state_nxt = IDLE;
      endcase
      if (halted) state_nxt = IDLE;
   end

   always_comb begin
      wdat = ex_ALUOut;
      case (ex_regSel)
         2'd0: wdat = ex_ALUOut;
         2'd1: wdat = (state == DONE) ? load_buf : dmemload;
         2'd2: wdat = ex_nPC;
         2'd3: wdat = {ex_ALUOut[15:0], {(WORD_W-16){1'b0}}};
         default: wdat = ex_ALUOut;
      endcase
   end

   assign fwd_valid = ex_regWr & ((ex_regSel != 2'd1) | dhit | (state == DONE));
   assign fwd_reg   = ex_regWr ? ex_regDst : '0;
   assign fwd_dat   = wdat;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state    <= IDLE;
         halted   <= 1'b0;
         load_buf <= '0;
      end else begin
         state <= state_nxt;
         if (ex_halt && wb_en) halted <= 1'b1;
         if (active && dhit)   load_buf <= dmemload;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wb_regWr  <= 1'b0;
         wb_regDst <= '0;
         wb_wdat   <= '0;
         wb_halt   <= 1'b0;
         wb_instr  <= '0;
      end else if (flush) begin
         wb_regWr  <= 1'b0;
         wb_regDst <= '0;
         wb_wdat   <= '0;
         wb_halt   <= 1'b0;
         wb_instr  <= '0;
      end else if (wb_en && !mem_stall) begin
         wb_regWr  <= ex_regWr;
         wb_regDst <= ex_regDst;
         wb_wdat   <= wdat;
         wb_halt   <= ex_halt;
         wb_instr  <= ex_instr;
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed vector table, random transactions against
// a transaction-level model, and hand-written multi-cycle sequences.
module tb_memory_stage;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        ex_dREN, ex_dWEN, ex_regWr, ex_halt;
   logic [1:0]  ex_regSel;
   logic [4:0]  ex_regDst;
   logic [31:0] ex_ALUOut, ex_store, ex_nPC, ex_instr;
   logic        wb_en, flush, dhit;
   logic [31:0] dmemload;
   logic        dmemREN, dmemWEN, mem_stall, fwd_valid;
   logic [31:0] dmemaddr, dmemstore, fwd_dat, wb_wdat, wb_instr;
   logic [4:0]  fwd_reg, wb_regDst;
   logic        wb_regWr, wb_halt;

   int errors = 0;
   int checks = 0;

   memory_stage dut (
      .CLK(CLK), .nRST(nRST),
      .ex_dREN(ex_dREN), .ex_dWEN(ex_dWEN), .ex_regWr(ex_regWr),
      .ex_regSel(ex_regSel), .ex_regDst(ex_regDst), .ex_halt(ex_halt),
      .ex_ALUOut(ex_ALUOut), .ex_store(ex_store), .ex_nPC(ex_nPC),
      .ex_instr(ex_instr), .wb_en(wb_en), .flush(flush), .dhit(dhit),
      .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
      .dmemaddr(dmemaddr), .dmemstore(dmemstore), .mem_stall(mem_stall),
      .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_dat(fwd_dat),
      .wb_regWr(wb_regWr), .wb_regDst(wb_regDst), .wb_wdat(wb_wdat),
      .wb_halt(wb_halt), .wb_instr(wb_instr)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [1:0]  sel;
      logic        ren, wen, hit;
      logic [31:0] alu, npc, load;
      logic [31:0] exp_wdat;
      logic        exp_ren, exp_wen, exp_fv;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      ex_dREN = 0; ex_dWEN = 0; ex_regWr = 0; ex_halt = 0; ex_regSel = 0;
      ex_regDst = 0; ex_ALUOut = 0; ex_store = 0; ex_nPC = 0; ex_instr = 0;
      wb_en = 1; flush = 0; dhit = 0; dmemload = 0;
   endtask

   // Transaction-level reference: the value written back depends only on the
   // source select; a mem op stalls for its wait count and requests once per
   // cycle until it completes, never after.
   function automatic logic [31:0] model_wdat(input logic [1:0] sel, input logic [31:0] alu,
                                              input logic [31:0] npc, input logic [31:0] ld);
      case (sel)
         2'd1:    return ld;
         2'd2:    return npc;
         2'd3:    return alu * 32'd65536;
         default: return alu;
      endcase
   endfunction

   task automatic run_txn(input int n);
      int kind, lat, hold, stalls, reqs;
      logic [31:0] alu, npc, data;
      logic [1:0] sel;
      logic [4:0] dst;
      kind = $urandom_range(0, 2);
      lat  = (kind == 0) ? 0 : $urandom_range(0, 3);
      hold = $urandom_range(0, 2);
      alu  = $urandom; npc = $urandom; data = $urandom;
      dst  = 5'($urandom_range(1, 31));
      if (kind == 1) sel = 2'd1;
      else begin
         case ($urandom_range(0, 2))
            0: sel = 2'd0;
            1: sel = 2'd2;
            default: sel = 2'd3;
         endcase
      end
      ex_dREN = (kind == 1); ex_dWEN = (kind == 2); ex_regWr = 1; ex_regSel = sel;
      ex_regDst = dst; ex_ALUOut = alu; ex_nPC = npc; ex_store = $urandom;
      ex_instr = $urandom; flush = 0;
      stalls = 0; reqs = 0;
      for (int c = 0; c <= lat; c++) begin
         dhit = (kind != 0) && (c == lat);
         dmemload = dhit ? data : $urandom;
         wb_en = (c == lat) ? (hold == 0) : 1'b1;
         #3;
         reqs += int'(dmemREN | dmemWEN);
         stalls += int'(mem_stall);
         step();
      end
      for (int h = 0; h < hold; h++) begin
         dhit = 0; dmemload = $urandom;
         wb_en = (h == hold - 1);
         #3;
         reqs += int'(dmemREN | dmemWEN);
         stalls += int'(mem_stall);
         step();
      end
      dhit = 0;
      chk($sformatf("rnd%0d stall cycles", n), 32'(stalls), 32'(lat));
      chk($sformatf("rnd%0d request cycles", n), 32'(reqs), (kind == 0) ? 32'd0 : 32'(lat + 1));
      chk($sformatf("rnd%0d wb_wdat", n), wb_wdat, model_wdat(sel, alu, npc, data));
      chk($sformatf("rnd%0d wb_regDst", n), 32'(wb_regDst), 32'(dst));
   endtask

   initial begin
      int wcount;
      idle_inputs();
      nRST = 0;
      ex_dREN = 1;
      #2;
      chk("reset dmemREN", 32'(dmemREN), 0);
      chk("reset wb_wdat", wb_wdat, 0);
      chk("reset wb_regWr", 32'(wb_regWr), 0);
      chk("reset wb_halt", 32'(wb_halt), 0);
      ex_dREN = 0;
      step();
      nRST = 1;
      step();

      //          sel   ren  wen  hit  alu            npc           load           wdat           ren  wen  fv
      tbl[0] = '{2'd0, 1'b0, 1'b0, 1'b0, 32'h1234,     32'h0,       32'h0,        32'h1234,      1'b0, 1'b0, 1'b1};
      tbl[1] = '{2'd3, 1'b0, 1'b0, 1'b0, 32'hABCD5678, 32'h0,       32'h0,        32'h56780000,  1'b0, 1'b0, 1'b1};
      tbl[2] = '{2'd2, 1'b0, 1'b0, 1'b0, 32'h0,        32'h404,     32'h0,        32'h404,       1'b0, 1'b0, 1'b1};
      tbl[3] = '{2'd1, 1'b1, 1'b0, 1'b1, 32'h300,      32'h0,       32'hDEADBEEF, 32'hDEADBEEF,  1'b1, 1'b0, 1'b1};
      tbl[4] = '{2'd0, 1'b0, 1'b1, 1'b1, 32'h200,      32'h0,       32'h11,       32'h200,       1'b0, 1'b1, 1'b1};
      tbl[5] = '{2'd1, 1'b1, 1'b1, 1'b1, 32'h204,      32'h0,       32'h55AA,     32'h55AA,      1'b1, 1'b0, 1'b1};
      tbl[6] = '{2'd1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,       32'h77,       32'h77,        1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 7; i++) begin
         ex_regSel = tbl[i].sel; ex_dREN = tbl[i].ren; ex_dWEN = tbl[i].wen;
         dhit = tbl[i].hit; ex_ALUOut = tbl[i].alu; ex_nPC = tbl[i].npc;
         dmemload = tbl[i].load; ex_regWr = 1; ex_regDst = 5'(8 + i); wb_en = 1;
         #3;
         chk($sformatf("vec%0d dmemREN", i), 32'(dmemREN), 32'(tbl[i].exp_ren));
         chk($sformatf("vec%0d dmemWEN", i), 32'(dmemWEN), 32'(tbl[i].exp_wen));
         chk($sformatf("vec%0d mem_stall", i), 32'(mem_stall), 0);
         chk($sformatf("vec%0d fwd_valid", i), 32'(fwd_valid), 32'(tbl[i].exp_fv));
         chk($sformatf("vec%0d fwd_reg", i), 32'(fwd_reg), 32'(8 + i));
         step();
         chk($sformatf("vec%0d wb_wdat", i), wb_wdat, tbl[i].exp_wdat);
         chk($sformatf("vec%0d wb_regDst", i), 32'(wb_regDst), 32'(8 + i));
      end
      idle_inputs();
      step();

      for (int n = 0; n < 25; n++) run_txn(n);
      idle_inputs();
      step();

      // Load with three wait cycles.
      ex_dREN = 1; ex_regWr = 1; ex_regSel = 1; ex_regDst = 5'd3; ex_ALUOut = 32'h100;
      wcount = 0;
      for (int c = 0; c < 3; c++) begin
         #3;
         wcount += int'(mem_stall);
         chk("busy dmemREN held", 32'(dmemREN), 1);
         chk("busy dmemaddr", dmemaddr, 32'h100);
         step();
      end
      chk("load stall cycles", 32'(wcount), 3);
      chk("load-use fwd_valid in BUSY", 32'(fwd_valid), 0);
      dhit = 1; dmemload = 32'hCAFEF00D;
      #3;
      chk("load hit mem_stall", 32'(mem_stall), 0);
      step();
      chk("load wb_wdat", wb_wdat, 32'hCAFEF00D);
      idle_inputs();
      step();

      // Store hit with writeback held off: exactly one write.
      ex_dWEN = 1; ex_ALUOut = 32'h180; ex_store = 32'h5A5A; dhit = 1; wb_en = 0;
      wcount = 0;
      #3;
      wcount += int'(dmemWEN);
      chk("store dmemstore", dmemstore, 32'h5A5A);
      step();
      dhit = 0;
      for (int c = 0; c < 2; c++) begin
         #3;
         wcount += int'(dmemWEN);
         chk("store DONE mem_stall", 32'(mem_stall), 0);
         step();
      end
      chk("store write cycles", 32'(wcount), 1);
      wb_en = 1;
      step();
      idle_inputs();
      step();

      // Load hit buffered across a writeback hold.
      ex_dREN = 1; ex_regWr = 1; ex_regSel = 1; ex_regDst = 5'd9; ex_ALUOut = 32'h1C0;
      dhit = 1; dmemload = 32'h600DCAFE; wb_en = 0;
      step();
      dhit = 0; dmemload = 32'h0;
      step();
      #3;
      chk("DONE fwd_valid", 32'(fwd_valid), 1);
      chk("DONE fwd_dat buffered", fwd_dat, 32'h600DCAFE);
      chk("DONE no re-request", 32'(dmemREN), 0);
      step();
      wb_en = 1;
      step();
      chk("buffered wb_wdat", wb_wdat, 32'h600DCAFE);
      idle_inputs();

      // Flush beats wb_en.
      ex_regWr = 1; ex_regDst = 5'd12; ex_ALUOut = 32'h77; ex_instr = 32'hABCD;
      step();
      chk("pre-flush wb_wdat", wb_wdat, 32'h77);
      flush = 1;
      step();
      chk("flush wb_wdat", wb_wdat, 0);
      chk("flush wb_regDst", 32'(wb_regDst), 0);
      chk("flush wb_regWr", 32'(wb_regWr), 0);
      chk("flush wb_instr", wb_instr, 0);
      idle_inputs();

      // Reset during BUSY withdraws the request at once.
      ex_dREN = 1; ex_ALUOut = 32'h240;
      step();
      #2;
      chk("BUSY before reset", 32'(mem_stall), 1);
      nRST = 0;
      #1;
      chk("reset mid-access dmemREN", 32'(dmemREN), 0);
      chk("reset mid-access mem_stall", 32'(mem_stall), 0);
      ex_dREN = 0;
      step();
      nRST = 1;
      step();
      #3;
      chk("after reset dmemREN", 32'(dmemREN), 0);
      ex_dREN = 1; dhit = 1; dmemload = 32'h31;
      #1;
      chk("after reset zero-wait stall", 32'(mem_stall), 0);
      step();
      idle_inputs();

      // Halt makes the stage inert.
      ex_halt = 1;
      step();
      chk("wb_halt", 32'(wb_halt), 1);
      ex_halt = 0; ex_dWEN = 1; ex_ALUOut = 32'h300;
      #3;
      chk("halted dmemWEN", 32'(dmemWEN), 0);
      chk("halted mem_stall", 32'(mem_stall), 0);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
